// File: rtl/nor_pkg.sv
// Shared constants and the bitwise NOR helper used across the NOR library cells.
package nor_pkg;

  localparam int unsigned NOR_WIDTH_DEF = 1;
  localparam int unsigned NOR_CNT_W_DEF = 16;
  // Widest operand the helper handles; callers zero-extend into this width.
  localparam int unsigned NOR_MAX_W     = 64;

  function automatic logic [NOR_MAX_W-1:0] nor_vec(input logic [NOR_MAX_W-1:0] x,
                                                   input logic [NOR_MAX_W-1:0] y);
    return ~(x | y);
  endfunction

endpackage

// File: rtl/nor_2x1_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter
  import nor_pkg::*;
#(
  parameter int unsigned CNT_W = NOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nor_2x1.sv
// Bitwise NOR cell: combinational result, valid-qualified registered copy,
// and a saturating count of valid all-ones results.
module nor_2x1
  import nor_pkg::*;
#(
  parameter int unsigned WIDTH = NOR_WIDTH_DEF,
  parameter int unsigned CNT_W = NOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  logic [NOR_MAX_W-1:0] a_ext;
  logic [NOR_MAX_W-1:0] b_ext;
  logic [NOR_MAX_W-1:0] nor_ext;
  logic                 all_ones;
  logic                 unused_hi;

  // Operands are widened to the helper's fixed width; only the low WIDTH bits matter.
  always_comb begin
    a_ext             = '0;
    b_ext             = '0;
    a_ext[WIDTH-1:0]  = a;
    b_ext[WIDTH-1:0]  = b;
  end

  assign nor_ext   = nor_vec(a_ext, b_ext);
  assign out       = nor_ext[WIDTH-1:0];
  assign all_ones  = &out;
  assign unused_hi = ^nor_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (in_valid & all_ones),
    .clr  (clr_cnt),
    .count(hit_cnt)
  );

endmodule

// File: tb/tb_nor_2x1.sv
// Directed bench for nor_2x1 across three configurations (1/16, 1/3, 8/16).
module tb_nor_2x1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=1, CNT_W=16
  logic       a1, b1, v1, c1, out1, q1, ov1;
  logic [15:0] h1;
  // WIDTH=1, CNT_W=3
  logic       a3, b3, v3, c3, out3, q3, ov3;
  logic [2:0] h3;
  // WIDTH=8, CNT_W=16
  logic [7:0] a8, b8, out8, q8;
  logic       v8, c8, ov8;
  logic [15:0] h8;

  int checks = 0;
  int errors = 0;

  nor_2x1 #(.WIDTH(1), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .out(out1), .in_valid(v1),
    .out_q(q1), .out_valid(ov1), .clr_cnt(c1), .hit_cnt(h1));

  nor_2x1 #(.WIDTH(1), .CNT_W(3)) d3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .out(out3), .in_valid(v3),
    .out_q(q3), .out_valid(ov3), .clr_cnt(c3), .hit_cnt(h3));

  nor_2x1 #(.WIDTH(8), .CNT_W(16)) d8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .out(out8), .in_valid(v8),
    .out_q(q8), .out_valid(ov8), .clr_cnt(c8), .hit_cnt(h8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tt;
  logic [7:0] pat;

  initial begin
    rst_n = 1'b0;
    {a1, b1, v1, c1} = '0;
    {a3, b3, v3, c3} = '0;
    a8 = '0; b8 = '0; v8 = 1'b0; c8 = 1'b0;
    #3;
    chk("rst_out_q", 32'(q1), 32'h0);
    chk("rst_out_valid", 32'(ov1), 32'h0);
    chk("rst_hit_cnt", 32'(h1), 32'h0);

    // Truth table during reset: combinational path needs no clock or reset release.
    tt = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      a1 = 1'((i >> 1) & 1);
      b1 = 1'(i & 1);
      #1;
      chk($sformatf("truth_%0d%0d", a1, b1), 32'(out1), 32'(tt[i]));
      #99;
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Registered path
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    tick();
    chk("reg_q_01", 32'(q1), 32'h0);
    chk("reg_v_01", 32'(ov1), 32'h1);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0;
    tick();
    chk("reg_q_00", 32'(q1), 32'h1);
    chk("reg_v_00", 32'(ov1), 32'h1);
    chk("reg_hit_1", 32'(h1), 32'h1);
    @(negedge clk);
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
    tick();
    chk("drop_valid", 32'(ov1), 32'h0);
    chk("drop_hold_q", 32'(q1), 32'h1);
    chk("drop_hit_hold", 32'(h1), 32'h1);

    // Counter: clear, then 5 hits interleaved with 3 non-hits
    @(negedge clk);
    c1 = 1'b1;
    tick();
    chk("clr_idle", 32'(h1), 32'h0);
    @(negedge clk);
    c1 = 1'b0;
    pat = 8'b00101010;  // bit i=1 -> a=b=1 (no hit), 0 -> a=b=0 (hit)
    for (int i = 0; i < 8; i++) begin
      a1 = pat[i]; b1 = pat[i]; v1 = 1'b1;
      tick();
      @(negedge clk);
    end
    chk("cnt_5", 32'(h1), 32'h5);

    // Clear together with a hit: clear wins
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b1; c1 = 1'b1;
    tick();
    chk("clr_vs_hit", 32'(h1), 32'h0);
    @(negedge clk);
    c1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
    end
    chk("pre_rst_hit", 32'(h1), 32'h4);
    chk("pre_rst_q", 32'(q1), 32'h1);

    // Async reset between edges
    #2;
    a1 = 1'b1; b1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_q", 32'(q1), 32'h0);
    chk("arst_valid", 32'(ov1), 32'h0);
    chk("arst_hit", 32'(h1), 32'h0);
    chk("arst_out_10", 32'(out1), 32'h0);
    a1 = 1'b0;
    #1;
    chk("arst_out_00", 32'(out1), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b0;

    // Saturation with CNT_W=3
    a3 = 1'b0; b3 = 1'b0; v3 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) chk("sat_6", 32'(h3), 32'h6);
      if (i == 7) chk("sat_7", 32'(h3), 32'h7);
      if (i == 8) chk("sat_8", 32'(h3), 32'h7);
      @(negedge clk);
    end
    chk("sat_10", 32'(h3), 32'h7);
    v3 = 1'b0;

    // WIDTH=8
    a8 = 8'h0F; b8 = 8'h30;
    #1;
    chk("w8_out", 32'(out8), 32'hC0);
    v8 = 1'b1;
    tick();
    chk("w8_q", 32'(q8), 32'hC0);
    chk("w8_valid", 32'(ov8), 32'h1);
    chk("w8_hit_none", 32'(h8), 32'h0);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00;
    #1;
    chk("w8_out_ff", 32'(out8), 32'hFF);
    tick();
    chk("w8_q_ff", 32'(q8), 32'hFF);
    chk("w8_hit_1", 32'(h8), 32'h1);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h00;
    tick();
    chk("w8_q_7f", 32'(q8), 32'h7F);
    chk("w8_hit_hold", 32'(h8), 32'h1);
    v8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nor_2x1.md
# nor_2x1

Two-input bitwise NOR primitive for the lab logic library, with an optional registered output stage and a saturating event counter. It provides a zero-latency combinational result for glue logic and a one-cycle registered, valid-qualified copy for pipelined datapaths. It is a leaf cell with no downstream dependencies.

## Interface
Parameters:
- WIDTH, 1, bit width of operands and results; each bit is an independent NOR.
- CNT_W, 16, width of the all-ones event counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational result, ~(a | b).
- in_valid  input  1  qualifies a/b for the registered stage and the counter.
- out_q  output  WIDTH  registered result.
- out_valid  output  1  high when out_q holds a result captured from a valid input.
- clr_cnt  input  1  synchronous clear of hit_cnt.
- hit_cnt  output  CNT_W  saturating count of valid cycles where out is all ones.

## Operation
- out = ~(a | b) bitwise, at all times, independent of clk, rst_n, and in_valid. For WIDTH=1: 00->1, 01->0, 10->0, 11->0.
- Registered stage: on each clock edge with in_valid=1, out_q <= ~(a | b) and out_valid <= 1.
- With in_valid=0, out_q holds its value and out_valid <= 0.
- Hit counter: increments by 1 on a clock edge when in_valid=1 and ~(a | b) is all ones (a==0 and b==0).
- Hit counter saturates at 2^CNT_W-1; it never wraps.
- If clr_cnt=1, hit_cnt <= 0 on that edge. Clear wins over a simultaneous increment.
- X/Z on a or b propagates per standard NOR semantics. No special handling.

## Timing
- out: zero cycles, purely combinational path from a/b.
- out_q, out_valid: one-cycle latency from the in_valid sample edge.
- hit_cnt: updates one cycle after the qualifying edge.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Reset (rst_n=0), asynchronous, effective immediately:
  - out_q=0, out_valid=0, hit_cnt=0.
  - out keeps following a/b during reset.
- Reset deasserted mid-stream: the first valid input sampled after deassertion produces out_valid on the following edge. Earlier inputs are lost.

## Structure
- Shared package nor_pkg:
  - default constants NOR_WIDTH_DEF=1 and NOR_CNT_W_DEF=16.
  - helper function computing the bitwise NOR of two vectors.
- One natural sub-module: sat_counter (CNT_W, inc, clr, async active-low reset, count output), instantiated once for hit_cnt.
- The remainder of the logic sits in the top module nor_2x1.

## Test plan
- Truth table, WIDTH=1, 100 ns per step: (a,b) = 00, 01, 10, 11 -> out = 1, 0, 0, 0 combinationally, with no clock dependence.
- Registered path: in_valid=1 with a=0, b=1 then a=0, b=0 on consecutive edges -> out_q = 0 then 1, with out_valid=1, each one cycle after its sample edge. Drop in_valid -> out_valid=0 and out_q holds 1.
- Counter: 5 valid cycles of a=b=0 interleaved with 3 valid cycles of a=1, b=1 -> hit_cnt=5. Assert clr_cnt together with a hit -> hit_cnt=0.
- Saturation (CNT_W=3): 10 consecutive valid a=b=0 cycles -> hit_cnt stops at 7 and does not wrap to 0.
- Async reset mid-operation: pull rst_n low between clock edges while out_q=1 and hit_cnt=4 -> out_q=0, out_valid=0, hit_cnt=0 immediately. Meanwhile out still equals ~(a|b).
- WIDTH=8: a=8'h0F, b=8'h30 -> out=8'hC0. Valid sample -> out_q=8'hC0 next cycle, and hit_cnt is unchanged because the result is not all ones.
